// File: rtl/siso_pkg.sv
// Shared definitions for the serial frame transmitter and the SIPO receivers.
package siso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Line levels; the receiver keys on a high start bit out of a low idle line.
  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b0;

endpackage

// File: rtl/bit_tick_counter.sv
// Bit-period timer: tick marks the last clock of each BIT_CYCLES-long bit.
module bit_tick_counter #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // With BIT_CYCLES=1 LAST is 0, so tick is high on every non-cleared clock.
  assign tick = !clear && (r_cnt == LAST);

  // Count 0..LAST and wrap at each bit boundary; held at 0 while cleared.
  always_ff @(posedge clk) begin
    if (rst || clear)
      r_cnt <= '0;
    else if (r_cnt == LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out framed transmitter: start bit, WIDTH data bits, stop bit.
module piso_frame_tx
  import siso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             frame_done
);

  // Bit counter reaches WIDTH after the last data bit, so it needs WIDTH+1 codes.
  localparam int BCW = $clog2(WIDTH + 1);

  tx_state_t        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [BCW-1:0]   r_bitcnt, w_bitcnt_nxt;
  logic             r_sout, r_din_ready, r_busy, r_frame_done;
  logic             w_tick, w_clear, w_xfer, w_head_nxt, w_sout_nxt;

  assign w_clear = (r_state == IDLE);
  assign w_xfer  = din_valid && r_din_ready;

  bit_tick_counter #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .tick (w_tick)
  );

  // Next-state, shift and bit-count logic; sout is derived from the next state
  // so the registered line shows each bit in the first cycle of its state.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_shift_nxt  = din;
          w_bitcnt_nxt = '0;
          w_state_nxt  = START;
        end
      end
      START: begin
        if (w_tick) begin
          w_bitcnt_nxt = '0;
          w_state_nxt  = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt  = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shift[WIDTH-1:1]};
          w_bitcnt_nxt = r_bitcnt + BCW'(1);
          if (r_bitcnt == BCW'(WIDTH - 1))
            w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_bitcnt_nxt = '0;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_head_nxt = MSB_FIRST ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];

    w_sout_nxt = IDLE_LEVEL;
    case (w_state_nxt)
      START:   w_sout_nxt = START_LEVEL;
      DATA:    w_sout_nxt = w_head_nxt;
      STOP:    w_sout_nxt = STOP_LEVEL;
      default: w_sout_nxt = IDLE_LEVEL;
    endcase
  end

  // State and output registers; rst aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_sout       <= IDLE_LEVEL;
      r_din_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_sout       <= w_sout_nxt;
      r_din_ready  <= (w_state_nxt == IDLE);
      r_busy       <= (w_state_nxt != IDLE);
      r_frame_done <= (r_state == STOP) && w_tick;
    end
  end

  assign sout       = r_sout;
  assign din_ready  = r_din_ready;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: three configurations checked against a frame model.
module tb_piso_frame_tx;

  typedef bit bitq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din_s [3];
  logic        vld_s [3];
  logic        rdy [3];
  logic        so  [3];
  logic        bz  [3];
  logic        fd  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 0: W8 BC1 MSB-first, 1: W8 BC1 LSB-first, 2: W4 BC3 MSB-first
  piso_frame_tx #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din_s[0][7:0]), .din_valid(vld_s[0]),
    .din_ready(rdy[0]), .sout(so[0]), .busy(bz[0]), .frame_done(fd[0]));

  piso_frame_tx #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din_s[1][7:0]), .din_valid(vld_s[1]),
    .din_ready(rdy[1]), .sout(so[1]), .busy(bz[1]), .frame_done(fd[1]));

  piso_frame_tx #(.WIDTH(4), .BIT_CYCLES(3), .MSB_FIRST(1'b1)) u_str (
    .clk(clk), .rst(rst), .din(din_s[2][3:0]), .din_valid(vld_s[2]),
    .din_ready(rdy[2]), .sout(so[2]), .busy(bz[2]), .frame_done(fd[2]));

  function automatic int wid(int k);
    return (k == 2) ? 4 : 8;
  endfunction

  function automatic int bcy(int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic bit msb(int k);
    return (k != 1);
  endfunction

  // Expected line, one entry per clock from first start cycle to last stop cycle.
  function automatic bitq_t ref_frame(int k, logic [31:0] w);
    bitq_t q;
    bit    b;
    q = {};
    for (int c = 0; c < bcy(k); c++) q.push_back(1'b1);
    for (int j = 0; j < wid(k); j++) begin
      b = msb(k) ? w[wid(k) - 1 - j] : w[j];
      for (int c = 0; c < bcy(k); c++) q.push_back(b);
    end
    for (int c = 0; c < bcy(k); c++) q.push_back(1'b0);
    return q;
  endfunction

  // Handshake is due at the next posedge; follow the frame and the done cycle.
  task automatic expect_frame(input int k, input logic [31:0] w, input bit nxt_v,
                              input logic [31:0] nxt_w, input bit scramble,
                              input string tag);
    bitq_t e;
    e = ref_frame(k, w);
    @(posedge clk);
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      n_checks++;
      if (so[k] !== e[i]) begin
        n_fail++;
        $display("FAIL %s sout cyc%0d got=%b exp=%b", tag, i + 1, so[k], e[i]);
      end
      n_checks++;
      if ({bz[k], rdy[k], fd[k]} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s status cyc%0d busy/ready/done got=%b exp=100",
                 tag, i + 1, {bz[k], rdy[k], fd[k]});
      end
      if (scramble && i != e.size() - 1) begin
        din_s[k] = $urandom;
        vld_s[k] = 1'($urandom_range(0, 1));
      end else begin
        din_s[k] = nxt_w;
        vld_s[k] = nxt_v;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({bz[k], rdy[k], fd[k], so[k]} !== 4'b0110) begin
      n_fail++;
      $display("FAIL %s done-cycle busy/ready/done/sout got=%b exp=0110",
               tag, {bz[k], rdy[k], fd[k], so[k]});
    end
  endtask

  // Offer a word, wait (bounded) for ready, then check the frame.
  task automatic start_tx(input int k, input logic [31:0] w, input bit nxt_v,
                          input logic [31:0] nxt_w, input bit scramble,
                          input string tag);
    int n;
    @(negedge clk);
    din_s[k] = w;
    vld_s[k] = 1'b1;
    n = 0;
    while (rdy[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL %s ready-timeout got=%b exp=1", tag, rdy[k]);
      vld_s[k] = 1'b0;
    end else begin
      expect_frame(k, w, nxt_v, nxt_w, scramble, tag);
    end
  endtask

  task automatic check_idle(input int k, input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n_checks++;
      if ({so[k], bz[k], rdy[k], fd[k]} !== 4'b0010) begin
        n_fail++;
        $display("FAIL %s idle sout/busy/ready/done got=%b exp=0010",
                 tag, {so[k], bz[k], rdy[k], fd[k]});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din_s[k] = $urandom;
      vld_s[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({so[k], bz[k], rdy[k], fd[k]} !== 4'b0010) begin
        n_fail++;
        $display("FAIL reset inst%0d sout/busy/ready/done got=%b exp=0010",
                 k, {so[k], bz[k], rdy[k], fd[k]});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_msb_basic();
    start_tx(0, 32'hA5, 1'b0, 32'h0, 1'b0, "msb_a5");
    check_idle(0, 2, "msb_a5_after");
  endtask

  task automatic test_lsb();
    start_tx(1, 32'h01, 1'b0, 32'h0, 1'b0, "lsb_01");
    check_idle(1, 2, "lsb_01_after");
  endtask

  task automatic test_stretch();
    start_tx(2, 32'hA, 1'b0, 32'h0, 1'b0, "str_1010");
    check_idle(2, 2, "str_after");
  endtask

  task automatic test_back_to_back();
    start_tx(0, 32'h3C, 1'b1, 32'hC3, 1'b0, "b2b_3c");
    expect_frame(0, 32'hC3, 1'b0, 32'h0, 1'b0, "b2b_c3");
    check_idle(0, 2, "b2b_after");
  endtask

  task automatic test_valid_while_busy();
    start_tx(0, $urandom & 32'hFF, 1'b0, 32'h0, 1'b1, "busy_msb");
    check_idle(0, 3, "busy_msb_after");
    start_tx(2, $urandom & 32'hF, 1'b0, 32'h0, 1'b1, "busy_str");
    check_idle(2, 3, "busy_str_after");
  endtask

  task automatic test_random();
    int          k;
    logic [31:0] w, w2;
    bit          b2b;
    for (int it = 0; it < 8; it++) begin
      k   = $urandom_range(0, 2);
      w   = $urandom & ((32'd1 << wid(k)) - 32'd1);
      w2  = $urandom & ((32'd1 << wid(k)) - 32'd1);
      b2b = 1'($urandom_range(0, 1));
      start_tx(k, w, b2b, w2, 1'($urandom_range(0, 1)), "rnd");
      if (b2b) expect_frame(k, w2, 1'b0, 32'h0, 1'b0, "rnd_b2b");
      check_idle(k, 1, "rnd_after");
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    bit seen;
    @(negedge clk);
    din_s[0] = 32'hFF;
    vld_s[0] = 1'b1;
    n = 0;
    while (rdy[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    vld_s[0] = 1'b0;
    // cycle 1 start, cycles 2..4 data bits 0..2, cycle 5 data bit 3
    repeat (4) @(negedge clk);
    n_checks++;
    if ({bz[0], so[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid bit3 busy/sout got=%b exp=11", {bz[0], so[0]});
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({so[0], bz[0], rdy[0], fd[0]} !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstmid after-rst sout/busy/ready/done got=%b exp=0010",
               {so[0], bz[0], rdy[0], fd[0]});
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (fd[0] !== 1'b0 || so[0] !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL rstmid aborted-frame activity got=1 exp=0");
    end
  endtask

  initial begin
    test_reset();
    test_msb_basic();
    test_lsb();
    test_stretch();
    test_back_to_back();
    test_valid_while_busy();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
- Parallel-in, serial-out framed transmitter. It drives the serial line that our SISO shift chain and the SIPO receivers consume.
- Accepts one WIDTH-bit word per valid/ready handshake.
- Emits the word on a single wire as: start bit, WIDTH data bits, stop bit.
- Each bit is held for BIT_CYCLES clocks; the line then returns to idle level 0.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.
- BIT_CYCLES, 1, clocks per serial bit; legal range 1..65535.
- MSB_FIRST, 1, 1 = din[WIDTH-1] sent first; 0 = din[0] sent first.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- din  input  WIDTH  parallel word to transmit; sampled only on handshake.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  serial line, registered.
- busy  output  1  frame in progress (START, DATA or STOP).
- frame_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset values: sout=0, din_ready=1, busy=0, frame_done=0, state=IDLE, shift register=0, bit count=0, tick count=0.
- rst dominates everything. Asserting rst mid-frame aborts the frame; the next cycle shows reset values, and the partial word is discarded.
- Handshake: transfer occurs when din_valid && din_ready at a posedge.
  - din_ready = (state==IDLE); it is registered.
  - din may change freely when no transfer occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: sout=0. On transfer, load the shift register from din and go to START; din_ready drops the next cycle.
  - START: sout=1 for BIT_CYCLES clocks, then go to DATA with bit count=0.
  - DATA: sout = current head bit (MSB or LSB per MSB_FIRST) for BIT_CYCLES clocks. Then shift one position and increment the bit count. After WIDTH bits, go to STOP.
  - STOP: sout=0 for BIT_CYCLES clocks, then go to IDLE. Assert frame_done for exactly the first IDLE cycle; din_ready=1 in that same cycle.
- Latency: the first start-bit cycle on sout is the cycle after the handshake edge.
- Frame length: (WIDTH+2)*BIT_CYCLES clocks from the first start cycle to the last stop cycle.
- Back-to-back: if din_valid is high in the frame_done cycle, the transfer is accepted. Minimum gap between frames is 1 idle clock (sout=0).
- busy=1 in START, DATA and STOP; busy=0 in IDLE.
- The bit-time counter counts 0..BIT_CYCLES-1 and wraps to 0 at every bit boundary. BIT_CYCLES=1 means one clock per bit with no counter stall.
- The bit counter is width $clog2(WIDTH+1) and must not wrap inside DATA.
- din_valid asserted while busy: ignored, no stall. The producer must hold valid until ready.
- sout glitch-free: driven only from a flop.

Decomposition:
- Shared package siso_pkg holds:
  - the state enum tx_state_t {IDLE, START, DATA, STOP};
  - constants START_LEVEL=1'b1, STOP_LEVEL=1'b0, IDLE_LEVEL=1'b0, shared with the SIPO receiver.
- One sub-module: bit_tick_counter (parameter BIT_CYCLES; inputs clk, rst, clear; output tick). It pulses tick on the last clock of each bit period.
- The FSM, shift register and bit counter stay in piso_frame_tx.

Test Plan:
- Reset mid-frame: WIDTH=8, BIT_CYCLES=1, load 8'hFF, assert rst during DATA bit 3 -> next cycle sout=0, busy=0, din_ready=1. No frame_done ever pulses for that word.
- Basic MSB-first: WIDTH=8, BIT_CYCLES=1, MSB_FIRST=1, din=8'hA5 handshake at cycle 0 -> sout over cycles 1..10 = 1,1,0,1,0,0,1,0,1,0; frame_done at cycle 11; din_ready=0 in cycles 1..10.
- LSB-first: MSB_FIRST=0, din=8'h01 -> sout cycles 1..10 = 1,1,0,0,0,0,0,0,0,0.
- Stretched bits: BIT_CYCLES=3, WIDTH=4, din=4'b1010 MSB-first -> sout = 1x3, 1x3, 0x3, 1x3, 0x3, 0x3; frame length 18 clocks; frame_done one cycle after.
- Back-to-back: din_valid held high with 8'h3C then 8'hC3 -> second handshake in the frame_done cycle; second start bit exactly 1 idle clock after the first stop bit; both frames match the expected bit streams.
- Valid while busy: toggle din and din_valid during DATA -> the transmitted bits equal the originally loaded word, and no extra handshake occurs.
